// File: rtl/local_ejection_unit.sv
`default_nettype none
// ============================================================================
// Module      : local_ejection_unit (with its noc_params package)
// Description : Router local-port sink. Keeps per-VC FIFOs, returns on/off and
//               allocatable flow control, and delivers whole packets to the core.
// Revision    : 1.0 - initial release
// ============================================================================

package noc_params;
    localparam int VC_NUM           = 2;
    localparam int VC_SIZE          = 1;
    localparam int DEST_ADDR_SIZE_X = 4;
    localparam int DEST_ADDR_SIZE_Y = 4;
    localparam int PAYLOAD_SIZE     = 16;

    typedef enum logic [1:0] {
        HEAD     = 2'b00,
        BODY     = 2'b01,
        TAIL     = 2'b10,
        HEADTAIL = 2'b11
    } flit_label_t;

    typedef struct packed {
        flit_label_t                 flit_label;
        logic [VC_SIZE-1:0]          vc_id;
        logic [DEST_ADDR_SIZE_X-1:0] x_dest;
        logic [DEST_ADDR_SIZE_Y-1:0] y_dest;
        logic [PAYLOAD_SIZE-1:0]     payload;
    } flit_t;
endpackage

module local_ejection_unit
    import noc_params::*;
#(
    parameter int BUFFER_SIZE = 8,
    parameter int OFF_MARGIN  = 2,
    parameter int X_CURRENT   = 0,
    parameter int Y_CURRENT   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  flit_t             data_i,
    input  logic              is_valid_i,
    output logic [VC_NUM-1:0] is_on_off_o,
    output logic [VC_NUM-1:0] is_allocatable_o,
    output flit_t             data_o,
    output logic              is_valid_o,
    input  logic              ready_i,
    output logic [15:0]       pkt_count_o,
    output logic [VC_NUM-1:0] error_o
);

    localparam int PTR_W = $clog2(BUFFER_SIZE);
    localparam logic [PTR_W:0] c_FULL = (PTR_W+1)'(BUFFER_SIZE);
    localparam logic [PTR_W:0] c_ONE  = (PTR_W+1)'(1);
    localparam logic [DEST_ADDR_SIZE_X-1:0] c_X = DEST_ADDR_SIZE_X'(X_CURRENT);
    localparam logic [DEST_ADDR_SIZE_Y-1:0] c_Y = DEST_ADDR_SIZE_Y'(Y_CURRENT);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_PKT   = 2'd1;
    localparam logic [1:0] c_ST_STALL = 2'd2;

    logic [VC_NUM-1:0]  w_empty;
    logic [VC_NUM-1:0]  w_wr_en;
    logic [VC_NUM-1:0]  w_rd_en;
    flit_t              w_heads [VC_NUM];
    flit_t              w_head;
    logic               w_head_tail;
    logic               w_xfer;
    logic [VC_SIZE-1:0] w_sel;
    logic [VC_SIZE-1:0] w_rr_vc;
    logic               w_rr_found;
    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [VC_SIZE-1:0] r_lock_vc;
    logic [VC_SIZE-1:0] w_lock_next;
    logic [VC_SIZE-1:0] r_last;
    logic [15:0]        r_pkt_count;

    for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
        flit_t          r_mem [BUFFER_SIZE];
        logic [PTR_W:0] r_wptr;
        logic [PTR_W:0] r_rptr;
        logic [PTR_W:0] w_occ;
        logic [PTR_W:0] w_occ_next;
        logic           w_hit;
        logic           w_full;
        logic           w_is_head;
        logic           w_proto_err;
        logic           w_dest_err;
        logic           r_open;
        logic           r_err;
        logic           r_on_off;
        logic           r_alloc;

        // Pointers carry one extra bit so a full FIFO differs from an empty one
        assign w_occ       = r_wptr - r_rptr;
        assign w_full      = (w_occ == c_FULL);
        assign w_empty[v]  = (w_occ == '0);
        assign w_hit       = is_valid_i && (data_i.vc_id == VC_SIZE'(v));
        assign w_wr_en[v]  = w_hit && !w_full;
        assign w_rd_en[v]  = w_xfer && (w_sel == VC_SIZE'(v));
        assign w_heads[v]  = r_mem[r_rptr[PTR_W-1:0]];
        assign w_is_head   = (data_i.flit_label == HEAD) || (data_i.flit_label == HEADTAIL);
        assign w_proto_err = w_is_head ? r_open : !r_open;
        assign w_dest_err  = w_is_head && ((data_i.x_dest != c_X) || (data_i.y_dest != c_Y));
        assign w_occ_next  = w_occ + {{PTR_W{1'b0}}, w_wr_en[v]} - {{PTR_W{1'b0}}, w_rd_en[v]};

        always_ff @(posedge clk) begin
            if (w_wr_en[v]) begin
                r_mem[r_wptr[PTR_W-1:0]] <= data_i;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_wptr   <= '0;
                r_rptr   <= '0;
                r_open   <= 1'b0;
                r_err    <= 1'b0;
                r_on_off <= 1'b1;
                r_alloc  <= 1'b1;
            end else begin
                if (w_wr_en[v]) begin
                    r_wptr <= r_wptr + c_ONE;
                end
                if (w_rd_en[v]) begin
                    r_rptr <= r_rptr + c_ONE;
                end
                if (w_hit && (w_proto_err || w_dest_err || w_full)) begin
                    r_err <= 1'b1;
                end
                if (w_hit && (data_i.flit_label == HEAD)) begin
                    r_open <= 1'b1;
                end else if (w_hit && (data_i.flit_label == TAIL)) begin
                    r_open <= 1'b0;
                end
                r_on_off <= (BUFFER_SIZE - int'(w_occ_next)) > OFF_MARGIN;
                // A new packet claiming the VC wins over the old one releasing it
                if (w_wr_en[v] && w_is_head) begin
                    r_alloc <= 1'b0;
                end else if (w_rd_en[v] && w_head_tail) begin
                    r_alloc <= 1'b1;
                end
            end
        end

        assign is_on_off_o[v]      = r_on_off;
        assign is_allocatable_o[v] = r_alloc;
        assign error_o[v]          = r_err;
    end

    // Round-robin search starting just after the last VC served
    always_comb begin
        logic [VC_SIZE-1:0] v_idx;
        v_idx      = '0;
        w_rr_vc    = r_last;
        w_rr_found = 1'b0;
        for (int k = 1; k <= VC_NUM; k++) begin
            v_idx = VC_SIZE'((int'(r_last) + k) % VC_NUM);
            if (!w_rr_found && !w_empty[v_idx]) begin
                w_rr_found = 1'b1;
                w_rr_vc    = v_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_lock_vc <= '0;
        end else begin
            r_state   <= w_state_next;
            r_lock_vc <= w_lock_next;
        end
    end

    // STALL pins a non-HEAD flit that the core is refusing, so the grant holds
    always_comb begin
        w_state_next = r_state;
        w_lock_next  = r_lock_vc;
        case (r_state)
            c_ST_IDLE: begin
                if (is_valid_o) begin
                    if (w_head.flit_label == HEAD) begin
                        w_state_next = c_ST_PKT;
                        w_lock_next  = w_sel;
                    end else if (!ready_i) begin
                        w_state_next = c_ST_STALL;
                        w_lock_next  = w_sel;
                    end
                end
            end
            c_ST_PKT: begin
                if (w_xfer && w_head_tail) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            c_ST_STALL: begin
                if (w_xfer) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_sel      = r_lock_vc;
        is_valid_o = !w_empty[r_lock_vc];
        if (r_state == c_ST_IDLE) begin
            w_sel      = w_rr_vc;
            is_valid_o = w_rr_found;
        end
        w_head = w_heads[w_sel];
        data_o = is_valid_o ? w_head : '0;
        w_xfer = is_valid_o && ready_i;
    end

    assign w_head_tail = (w_head.flit_label == TAIL) || (w_head.flit_label == HEADTAIL);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last      <= '0;
            r_pkt_count <= '0;
        end else if (w_xfer) begin
            r_last <= w_sel;
            if (w_head_tail) begin
                r_pkt_count <= r_pkt_count + 16'd1;
            end
        end
    end

    assign pkt_count_o = r_pkt_count;

endmodule

`default_nettype wire

// File: tb/tb_local_ejection_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_local_ejection_unit
// Description : Directed and randomized bench against a queue-based packet model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_local_ejection_unit;
    import noc_params::*;

    localparam int BS = 8;
    localparam int OM = 2;
    localparam int XC = 1;
    localparam int YC = 2;

    logic              clk;
    logic              rst;
    flit_t             data_i;
    logic              is_valid_i;
    logic [VC_NUM-1:0] is_on_off_o;
    logic [VC_NUM-1:0] is_allocatable_o;
    flit_t             data_o;
    logic              is_valid_o;
    logic              ready_i;
    logic [15:0]       pkt_count_o;
    logic [VC_NUM-1:0] error_o;

    local_ejection_unit #(
        .BUFFER_SIZE(BS), .OFF_MARGIN(OM), .X_CURRENT(XC), .Y_CURRENT(YC)
    ) u_dut (
        .clk(clk), .rst(rst), .data_i(data_i), .is_valid_i(is_valid_i),
        .is_on_off_o(is_on_off_o), .is_allocatable_o(is_allocatable_o),
        .data_o(data_o), .is_valid_o(is_valid_o), .ready_i(ready_i),
        .pkt_count_o(pkt_count_o), .error_o(error_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Reference model: plain queues plus packet-level arbitration rules
    flit_t       mq [VC_NUM][$];
    int          m_owner;
    bit          m_own_pkt;
    int          m_last;
    bit          m_open  [VC_NUM];
    bit          m_err   [VC_NUM];
    bit          m_onoff [VC_NUM];
    bit          m_alloc [VC_NUM];
    logic [15:0] m_pkt;
    int          xlog[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic flit_t mk(flit_label_t l, int vc, int x, int y, int p);
        flit_t f;
        f.flit_label = l;
        f.vc_id      = VC_SIZE'(vc);
        f.x_dest     = DEST_ADDR_SIZE_X'(x);
        f.y_dest     = DEST_ADDR_SIZE_Y'(y);
        f.payload    = PAYLOAD_SIZE'(p);
        return f;
    endfunction

    task automatic model_reset();
        for (int v = 0; v < VC_NUM; v++) begin
            mq[v].delete();
            m_open[v]  = 1'b0;
            m_err[v]   = 1'b0;
            m_onoff[v] = 1'b1;
            m_alloc[v] = 1'b1;
        end
        m_owner   = -1;
        m_own_pkt = 1'b0;
        m_last    = 0;
        m_pkt     = '0;
    endtask

    task automatic model_out(output bit mv, output int s);
        mv = 1'b0;
        s  = m_last;
        if (m_owner >= 0) begin
            s  = m_owner;
            mv = mq[m_owner].size() > 0;
        end else begin
            for (int k = 1; k <= VC_NUM; k++) begin
                int c;
                c = (m_last + k) % VC_NUM;
                if (!mv && mq[c].size() > 0) begin
                    mv = 1'b1;
                    s  = c;
                end
            end
        end
    endtask

    task automatic model_step(input bit v, input flit_t f, input bit rdy);
        bit    mv;
        int    s;
        bit    xfer;
        bit    tl;
        bit    full;
        bit    is_hd;
        int    vc;
        flit_t hf;
        bit    clr  [VC_NUM];
        bit    setv [VC_NUM];
        for (int i = 0; i < VC_NUM; i++) begin
            clr[i]  = 1'b0;
            setv[i] = 1'b0;
        end
        hf = '0;
        tl = 1'b0;
        model_out(mv, s);
        if (mv) hf = mq[s][0];
        xfer = mv && rdy;
        vc   = int'(f.vc_id);
        full = (mq[vc].size() == BS);
        if (xfer) begin
            void'(mq[s].pop_front());
            tl = (hf.flit_label == TAIL) || (hf.flit_label == HEADTAIL);
            if (tl) begin
                m_pkt   = m_pkt + 16'd1;
                setv[s] = 1'b1;
            end
            m_last = s;
        end
        if (m_owner < 0) begin
            if (mv) begin
                if (hf.flit_label == HEAD) begin
                    m_owner = s; m_own_pkt = 1'b1;
                end else if (!xfer) begin
                    m_owner = s; m_own_pkt = 1'b0;
                end
            end
        end else if (xfer && (!m_own_pkt || tl)) begin
            m_owner = -1;
        end
        if (v) begin
            is_hd = (f.flit_label == HEAD) || (f.flit_label == HEADTAIL);
            if (is_hd == m_open[vc]) m_err[vc] = 1'b1;
            if (is_hd && (int'(f.x_dest) != XC || int'(f.y_dest) != YC)) m_err[vc] = 1'b1;
            if (full) begin
                m_err[vc] = 1'b1;
            end else begin
                mq[vc].push_back(f);
                if (is_hd) clr[vc] = 1'b1;
            end
            if (f.flit_label == HEAD) m_open[vc] = 1'b1;
            if (f.flit_label == TAIL) m_open[vc] = 1'b0;
        end
        for (int i = 0; i < VC_NUM; i++) begin
            if (clr[i]) m_alloc[i] = 1'b0;
            else if (setv[i]) m_alloc[i] = 1'b1;
            m_onoff[i] = (BS - mq[i].size()) > OM;
        end
    endtask

    task automatic compare_model();
        bit mv;
        int s;
        logic [VC_NUM-1:0] eo, ea, ee;
        model_out(mv, s);
        for (int i = 0; i < VC_NUM; i++) begin
            eo[i] = m_onoff[i];
            ea[i] = m_alloc[i];
            ee[i] = m_err[i];
        end
        chk("valid", 64'(is_valid_o), 64'(mv));
        if (mv) chk("data", 64'(data_o), 64'(mq[s][0]));
        chk("on_off", 64'(is_on_off_o), 64'(eo));
        chk("alloc", 64'(is_allocatable_o), 64'(ea));
        chk("error", 64'(error_o), 64'(ee));
        chk("pkt_count", 64'(pkt_count_o), 64'(m_pkt));
    endtask

    // One clock: check outputs, drive inputs, advance model, cross the edge
    task automatic cyc(input bit v, input flit_t f, input bit rdy);
        compare_model();
        is_valid_i = v;
        data_i     = f;
        ready_i    = rdy;
        if (is_valid_o && rdy) xlog.push_back(int'(data_o.payload));
        model_step(v, f, rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, rdy);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        is_valid_i = 1'b0;
        data_i     = '0;
        ready_i    = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        xlog.delete();
    endtask

    initial begin
        int          g_rem [VC_NUM];
        logic [15:0] pay;
        n_vec = 0;
        n_err = 0;
        rst        = 1'b1;
        is_valid_i = 1'b0;
        data_i     = '0;
        ready_i    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        chk("rst_valid", 64'(is_valid_o), 64'd0);
        chk("rst_data", 64'(data_o), 64'd0);
        chk("rst_on_off", 64'(is_on_off_o), 64'h3);
        chk("rst_alloc", 64'(is_allocatable_o), 64'h3);
        chk("rst_error", 64'(error_o), 64'd0);
        chk("rst_pkt", 64'(pkt_count_o), 64'd0);

        // Two-flit packet latency and allocatable timing
        cyc(1'b1, mk(HEAD, 0, XC, YC, 16'h0011), 1'b1);
        chk("t1_data_c1", 64'(data_o), 64'(mk(HEAD, 0, XC, YC, 16'h0011)));
        chk("t1_alloc_c1", 64'(is_allocatable_o[0]), 64'd0);
        cyc(1'b1, mk(TAIL, 0, XC, YC, 16'h0012), 1'b1);
        chk("t1_data_c2", 64'(data_o), 64'(mk(TAIL, 0, XC, YC, 16'h0012)));
        chk("t1_alloc_c2", 64'(is_allocatable_o[0]), 64'd0);
        idle(1, 1'b1);
        chk("t1_alloc_c3", 64'(is_allocatable_o[0]), 64'd1);
        chk("t1_pkt", 64'(pkt_count_o), 64'd1);
        chk("t1_err", 64'(error_o), 64'd0);

        // Fill VC1 with the core stalled: on/off threshold, then overflow
        do_reset();
        for (int i = 0; i < 9; i++) begin
            cyc(1'b1, mk((i == 0) ? HEAD : BODY, 1, XC, YC, 16'h0100 + i), 1'b0);
            if (i == 4) chk("t2_onoff_after5", 64'(is_on_off_o[1]), 64'd1);
            if (i == 5) chk("t2_onoff_after6", 64'(is_on_off_o[1]), 64'd0);
            if (i == 7) chk("t2_err_full", 64'(error_o[1]), 64'd0);
        end
        chk("t2_err_drop", 64'(error_o[1]), 64'd1);
        idle(8, 1'b1);
        cyc(1'b1, mk(TAIL, 1, XC, YC, 16'h01ff), 1'b1);
        idle(2, 1'b1);
        chk("t2_drain_cnt", 64'(xlog.size()), 64'd9);

        // Interleaved VCs: the VC0 packet must not be split by the VC1 flit
        do_reset();
        cyc(1'b1, mk(HEAD, 0, XC, YC, 16'h0030), 1'b1);
        cyc(1'b1, mk(HEADTAIL, 1, XC, YC, 16'h0031), 1'b1);
        cyc(1'b1, mk(BODY, 0, XC, YC, 16'h0032), 1'b1);
        idle(1, 1'b1);
        cyc(1'b1, mk(TAIL, 0, XC, YC, 16'h0033), 1'b1);
        idle(4, 1'b1);
        chk("t3_cnt", 64'(xlog.size()), 64'd4);
        if (xlog.size() == 4) begin
            chk("t3_ord0", 64'(xlog[0]), 64'h30);
            chk("t3_ord1", 64'(xlog[1]), 64'h32);
            chk("t3_ord2", 64'(xlog[2]), 64'h33);
            chk("t3_ord3", 64'(xlog[3]), 64'h31);
        end
        chk("t3_pkt", 64'(pkt_count_o), 64'd2);

        // Orphan BODY plus misrouted HEAD: sticky error, flits still delivered
        do_reset();
        cyc(1'b1, mk(BODY, 0, XC, YC, 16'h0040), 1'b1);
        cyc(1'b1, mk(HEAD, 0, 0, 0, 16'h0041), 1'b1);
        idle(3, 1'b1);
        chk("t4_err", 64'(error_o[0]), 64'd1);
        chk("t4_cnt", 64'(xlog.size()), 64'd2);
        cyc(1'b1, mk(TAIL, 0, XC, YC, 16'h0042), 1'b1);
        idle(3, 1'b1);
        chk("t4_err_sticky", 64'(error_o[0]), 64'd1);

        // Streaming through VC0 for 20 cycles across pointer wrap
        do_reset();
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, mk((i == 0) ? HEAD : ((i == 19) ? TAIL : BODY), 0, XC, YC, 100 + i), 1'b1);
            chk("t5_onoff", 64'(is_on_off_o[0]), 64'd1);
        end
        idle(2, 1'b1);
        chk("t5_cnt", 64'(xlog.size()), 64'd20);
        for (int i = 0; i < 20 && i < xlog.size(); i++) chk("t5_order", 64'(xlog[i]), 64'(100 + i));

        // Reset with a partial packet stored and an error pending
        do_reset();
        cyc(1'b1, mk(BODY, 1, XC, YC, 16'h0050), 1'b0);
        cyc(1'b1, mk(HEAD, 0, XC, YC, 16'h0051), 1'b0);
        cyc(1'b1, mk(BODY, 0, XC, YC, 16'h0052), 1'b0);
        cyc(1'b1, mk(BODY, 0, XC, YC, 16'h0053), 1'b0);
        do_reset();
        chk("t6_valid", 64'(is_valid_o), 64'd0);
        chk("t6_on_off", 64'(is_on_off_o), 64'h3);
        chk("t6_alloc", 64'(is_allocatable_o), 64'h3);
        chk("t6_error", 64'(error_o), 64'd0);
        cyc(1'b1, mk(HEADTAIL, 0, XC, YC, 16'h0054), 1'b1);
        chk("t6_ht_valid", 64'(is_valid_o), 64'd1);
        chk("t6_ht_data", 64'(data_o.payload), 64'h54);
        chk("t6_ht_err", 64'(error_o), 64'd0);
        idle(2, 1'b1);

        // Randomized traffic, mostly legal packets with occasional faults
        do_reset();
        for (int v = 0; v < VC_NUM; v++) g_rem[v] = -1;
        pay = 16'h1000;
        for (int i = 0; i < 3000; i++) begin
            bit          vin;
            bit          rdy;
            int          vc;
            int          x;
            int          y;
            flit_label_t l;
            vin = $urandom_range(0, 9) < 6;
            rdy = ((i % 400) < 40) ? 1'b0 : ($urandom_range(0, 9) < 7);
            vc  = $urandom_range(0, VC_NUM - 1);
            l   = BODY;
            if (g_rem[vc] < 0) begin
                if ($urandom_range(0, 9) < 3) begin
                    l = HEADTAIL;
                end else begin
                    l = HEAD;
                    g_rem[vc] = $urandom_range(0, 3);
                end
            end else if (g_rem[vc] > 0) begin
                l = BODY;
                g_rem[vc] = g_rem[vc] - 1;
            end else begin
                l = TAIL;
                g_rem[vc] = -1;
            end
            if ($urandom_range(0, 99) < 3) l = flit_label_t'($urandom_range(0, 3));
            x = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 15) : XC;
            y = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 15) : YC;
            if (vin) pay = pay + 16'd1;
            cyc(vin, mk(l, vc, x, y, int'(pay)), rdy);
        end
        idle(40, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/local_ejection_unit.md
Name: local_ejection_unit

Overview:
- Receiving end of a router's local output port. Sinks flits the router ejects and holds them in per-VC FIFOs.
- Drives the per-VC is_on_off / is_allocatable flow-control signals back to the router.
- Hands complete packets to the local core one flit per cycle, packet-contiguous, with valid/ready.
- Checks the packet protocol and the flit destination.

Parameters:
- BUFFER_SIZE, 8, flit slots per VC FIFO (power of 2, >=4).
- OFF_MARGIN, 2, free slots reserved for in-flight flits; on/off drops when free slots <= OFF_MARGIN.
- X_CURRENT, 0, mesh X coordinate of this node.
- Y_CURRENT, 0, mesh Y coordinate of this node.
- VC_NUM, flit_t, flit_label_t: taken from noc_params.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- data_i  in  flit_t  flit from the router local output.
- is_valid_i  in  1  data_i valid this cycle.
- is_on_off_o  out  VC_NUM  per-VC: router may send.
- is_allocatable_o  out  VC_NUM  per-VC: VC free for a new packet.
- data_o  out  flit_t  flit presented to the core.
- is_valid_o  out  1  data_o valid.
- ready_i  in  1  core accepts data_o; a transfer occurs when is_valid_o && ready_i.
- pkt_count_o  out  16  packets fully delivered (TAIL/HEADTAIL transferred); wraps at 2^16.
- error_o  out  VC_NUM  sticky per-VC protocol error.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
  - Reset flushes all FIFOs, clears packet-open flags, unlocks the output arbiter, zeroes pkt_count_o and error_o.
  - Reset values: is_on_off_o all 1, is_allocatable_o all 1, is_valid_o 0, data_o 0.
  - Reset mid-packet discards all partial data; no error is flagged.
- Write path: is_valid_i high writes data_i into the FIFO data_i.vc_id on that posedge.
  - The flit is stored unmodified, including its label.
  - Write to a full FIFO: flit dropped, error_o[vc] set.
- Protocol check per VC (open flag):
  - HEAD: sets open.
  - BODY: requires open.
  - TAIL: requires open, then clears open.
  - HEADTAIL: requires not open.
  - HEAD or HEADTAIL while open, or BODY or TAIL while not open: error_o[vc] set. The flit is still stored.
- Destination check: HEAD/HEADTAIL with x_dest != X_CURRENT or y_dest != Y_CURRENT sets error_o[vc]. The flit is still stored.
- is_on_off_o[v]: registered; equals (BUFFER_SIZE - occupancy_next) > OFF_MARGIN.
- is_allocatable_o[v]: registered.
  - Cleared on the cycle after a HEAD/HEADTAIL is written to v.
  - Set on the cycle after that packet's TAIL/HEADTAIL is transferred out on data_o.
- Read path: first-word fall-through.
  - A flit written at edge t may appear on data_o at cycle t+1 at the earliest (1-cycle latency).
  - data_o is the head of the selected VC FIFO; is_valid_o = the selected FIFO is non-empty.
- Arbiter FSM:
  - IDLE: round-robin pick among non-empty VCs, starting after the last served VC. Go to LOCKED if the picked head flit is HEAD.
  - LOCKED(v): serve only v until its TAIL transfers, then return to IDLE. If v is empty, is_valid_o = 0 and other VCs wait.
  - A HEADTAIL transfers from IDLE with no lock.
  - A BODY/TAIL at the head in IDLE (error case) transfers as a standalone flit.
- Simultaneous write and read on the same VC: occupancy unchanged. A read from an empty FIFO is impossible, since is_valid_o gates it.
- Pointers wrap modulo BUFFER_SIZE. Occupancy is tracked with one extra bit so full and empty are distinguishable.
- Holding: is_valid_o && !ready_i holds data_o stable, and the arbiter does not switch.

Test Plan:
- Reset, node (1,2), VC0: HEAD(dest 1,2) at cycle 0, TAIL at cycle 1, ready_i=1 -> data_o shows HEAD at cycle 1 and TAIL at cycle 2. is_allocatable_o[0] is 0 from cycle 1 to 2 and 1 again at cycle 3. pkt_count_o=1. error_o=0.
- ready_i=0, 7 flits (HEAD + 6 BODY) to VC1, BUFFER_SIZE=8, OFF_MARGIN=2 -> is_on_off_o[1] falls the cycle after the 6th write. An 8th write fills the buffer; a 9th is dropped and sets error_o[1].
- Interleave: VC0 HEAD,BODY,TAIL and VC1 HEADTAIL on alternating cycles, ready_i=1 -> data_o delivers the VC0 packet contiguously, never splitting it with the VC1 flit. pkt_count_o=2.
- BODY to VC0 with no open packet, then HEAD to VC0 with dest (0,0) at node (1,2) -> error_o[0]=1, sticky until rst. Both flits are delivered.
- Simultaneous write and transfer on VC0 for 20 cycles with ready_i=1 -> occupancy stays constant and is_on_off_o[0] stays 1. Pointer wrap causes no loss or reorder; data payloads are checked against a scoreboard.
- Assert rst while VC0 holds 3 flits mid-packet -> next cycle is_valid_o=0, is_on_off_o and is_allocatable_o all 1, error_o=0. A new HEADTAIL is then accepted without error.
